// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order CDB completion, in-order retire.
// Latency: commit and flush outputs are registered, one cycle after the head entry is ready.
// Backpressure: issue_ready drops when full, during rob_clear, or once halted; rdy_in=0 freezes all state.
// Optional: `define ROB_CDB_BYPASS_EN forwards a same-cycle CDB result onto the query ports.
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 3
`endif

module reorder_buffer #(
  parameter int ROB_SIZE_BIT = `ROB_SIZE_BIT
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    issue_valid,
  input  logic [1:0]              issue_type,
  input  logic [4:0]              issue_rd,
  input  logic [31:0]             issue_pc,
  input  logic                    issue_pred_taken,
  input  logic [31:0]             issue_jump_addr,
  output logic                    issue_ready,
  output logic [ROB_SIZE_BIT-1:0] issue_tag,
  input  logic                    cdb_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb_tag,
  input  logic [31:0]             cdb_value,
  input  logic                    cdb_taken,
  input  logic [ROB_SIZE_BIT-1:0] qry1_tag,
  input  logic [ROB_SIZE_BIT-1:0] qry2_tag,
  output logic                    qry1_ready,
  output logic                    qry2_ready,
  output logic [31:0]             qry1_val,
  output logic [31:0]             qry2_val,
  output logic [4:0]              rob_set_idx,
  output logic [31:0]             rob_set_reg_val,
  output logic [ROB_SIZE_BIT-1:0] rob_set_recorder,
  output logic                    store_commit,
  output logic [ROB_SIZE_BIT-1:0] store_commit_tag,
  output logic                    rob_clear,
  output logic                    redirect_valid,
  output logic [31:0]             redirect_pc,
  output logic                    halt
);

  localparam int DEPTH = 1 << ROB_SIZE_BIT;
  localparam int CNT_W = ROB_SIZE_BIT + 1;

  typedef enum logic [1:0] {
    T_REG    = 2'd0,
    T_BRANCH = 2'd1,
    T_STORE  = 2'd2,
    T_EXIT   = 2'd3
  } rob_type_e;

  typedef struct packed {
    rob_type_e   typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] jump_addr;
    logic [31:0] value;
    logic        taken;
  } entry_t;

  entry_t                  ent [DEPTH];
  logic [DEPTH-1:0]        ent_vld;
  logic [DEPTH-1:0]        ent_rdy;
  logic [ROB_SIZE_BIT-1:0] head;
  logic [ROB_SIZE_BIT-1:0] tail;
  logic [CNT_W-1:0]        count;

  entry_t head_ent;
  logic   commit_go;
  logic   mispredict;
  logic   issue_go;
  logic   cdb_go;

  assign issue_tag = tail;

  // Head retire decision, allocation handshake and CDB acceptance.
  always_comb begin
    head_ent    = ent[head];
    commit_go   = ent_vld[head] && ent_rdy[head] && !halt;
    mispredict  = commit_go && (head_ent.typ == T_BRANCH) && (head_ent.taken != head_ent.pred);
    // A full buffer that commits this cycle still refuses issue: the freed slot is reused next cycle.
    issue_ready = (count != CNT_W'(DEPTH)) && !rob_clear && !halt;
    issue_go    = issue_valid && issue_ready;
    // Results for squashed or never-allocated entries are dropped.
    cdb_go      = cdb_valid && !rob_clear && ent_vld[cdb_tag];
  end

  // Operand lookup from issue; optionally forwards the in-flight CDB broadcast.
  always_comb begin
    qry1_ready = ent_vld[qry1_tag] && ent_rdy[qry1_tag];
    qry1_val   = ent[qry1_tag].value;
    qry2_ready = ent_vld[qry2_tag] && ent_rdy[qry2_tag];
    qry2_val   = ent[qry2_tag].value;
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid && (cdb_tag == qry1_tag) && ent_vld[qry1_tag]) begin
      qry1_ready = 1'b1;
      qry1_val   = cdb_value;
    end
    if (cdb_valid && (cdb_tag == qry2_tag) && ent_vld[qry2_tag]) begin
      qry2_ready = 1'b1;
      qry2_val   = cdb_value;
    end
`endif
  end

  // Entry storage and head/tail/count bookkeeping; a mispredict squashes everything.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      ent_vld <= '0;
      ent_rdy <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else if (rdy_in) begin
      if (mispredict) begin
        ent_vld <= '0;
        ent_rdy <= '0;
        head    <= '0;
        tail    <= '0;
        count   <= '0;
      end else begin
        if (cdb_go) begin
          ent[cdb_tag].value <= cdb_value;
          ent[cdb_tag].taken <= cdb_taken;
          ent_rdy[cdb_tag]   <= 1'b1;
        end
        // Retire clears the head after any CDB write so a late result cannot resurrect it.
        if (commit_go) begin
          ent_vld[head] <= 1'b0;
          ent_rdy[head] <= 1'b0;
          head          <= head + 1'b1;
        end
        if (issue_go) begin
          ent[tail] <= '{typ:       rob_type_e'(issue_type),
                         rd:        issue_rd,
                         pc:        issue_pc,
                         pred:      issue_pred_taken,
                         jump_addr: issue_jump_addr,
                         value:     32'd0,
                         taken:     1'b0};
          ent_vld[tail] <= 1'b1;
          ent_rdy[tail] <= 1'b0;
          tail          <= tail + 1'b1;
        end
        case ({issue_go, commit_go})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Registered retire outputs: one-cycle pulses, except halt which is sticky.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rob_set_idx      <= '0;
      rob_set_reg_val  <= '0;
      rob_set_recorder <= '0;
      store_commit     <= 1'b0;
      store_commit_tag <= '0;
      rob_clear        <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      halt             <= 1'b0;
    end else if (rdy_in) begin
      rob_set_idx      <= '0;
      rob_set_reg_val  <= '0;
      rob_set_recorder <= '0;
      store_commit     <= 1'b0;
      store_commit_tag <= '0;
      rob_clear        <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      if (commit_go) begin
        case (head_ent.typ)
          T_REG: begin
            rob_set_idx      <= head_ent.rd;
            rob_set_reg_val  <= head_ent.value;
            rob_set_recorder <= head;
          end
          T_STORE: begin
            store_commit     <= 1'b1;
            store_commit_tag <= head;
          end
          T_BRANCH: begin
            if (mispredict) begin
              rob_clear      <= 1'b1;
              redirect_valid <= 1'b1;
              redirect_pc    <= head_ent.taken ? head_ent.jump_addr : head_ent.pc + 32'd4;
            end
          end
          default: halt <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a queue-based program-order model.
// Latency: expected retire outputs are queued one half-cycle before the edge that produces them.
// Backpressure: rdy_in stalls are modelled as the previous output vector being held.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in, issue_valid, issue_pred_taken, cdb_valid, cdb_taken;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc, issue_jump_addr, cdb_value;
  logic        issue_ready;
  logic [2:0]  issue_tag, cdb_tag, qry1_tag, qry2_tag;
  logic        qry1_ready, qry2_ready;
  logic [31:0] qry1_val, qry2_val;
  logic [4:0]  rob_set_idx;
  logic [31:0] rob_set_reg_val;
  logic [2:0]  rob_set_recorder, store_commit_tag;
  logic        store_commit, rob_clear, redirect_valid, halt;
  logic [31:0] redirect_pc;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken), .issue_jump_addr(issue_jump_addr),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
    .qry1_tag(qry1_tag), .qry2_tag(qry2_tag), .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
    .qry1_val(qry1_val), .qry2_val(qry2_val),
    .rob_set_idx(rob_set_idx), .rob_set_reg_val(rob_set_reg_val), .rob_set_recorder(rob_set_recorder),
    .store_commit(store_commit), .store_commit_tag(store_commit_tag),
    .rob_clear(rob_clear), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
  );

  always #5 clk_in = ~clk_in;

  // Program-order record of an in-flight instruction.
  typedef struct {
    logic [1:0]  ty;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] ja;
    logic [31:0] val;
    logic        tk;
    bit          done;
    int          tag;
  } ins_t;

  // Expected retire-side output vector after one clock edge.
  typedef struct {
    logic [4:0]  idx;
    logic [31:0] val;
    int          rec;
    logic        sc;
    int          st;
    logic        clr;
    logic        rv;
    logic [31:0] rpc;
    logic        halt;
  } out_t;

  ins_t q[$];
  out_t exp_q[$];
  out_t last_out;
  int   next_tag;
  bit   mon_en = 0;
  int   checks = 0;
  int   failures = 0;

  logic        s_iv, s_pred, s_cv, s_ctk, s_rdy;
  logic [1:0]  s_ty;
  logic [4:0]  s_rd;
  logic [31:0] s_pc, s_ja, s_cval;
  logic [2:0]  s_ct, s_q1, s_q2;

  function automatic out_t zero_out();
    out_t o;
    o.idx = 0; o.val = 0; o.rec = 0; o.sc = 0; o.st = 0;
    o.clr = 0; o.rv = 0; o.rpc = 0; o.halt = 0;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_set();
    s_iv = 0; s_ty = 0; s_rd = 0; s_pc = 0; s_pred = 0; s_ja = 0;
    s_cv = 0; s_ct = 0; s_cval = 0; s_ctk = 0; s_rdy = 1; s_q1 = 0; s_q2 = 0;
  endtask

  task automatic apply_inputs();
    rdy_in = s_rdy; issue_valid = s_iv; issue_type = s_ty; issue_rd = s_rd;
    issue_pc = s_pc; issue_pred_taken = s_pred; issue_jump_addr = s_ja;
    cdb_valid = s_cv; cdb_tag = s_ct; cdb_value = s_cval; cdb_taken = s_ctk;
    qry1_tag = s_q1; qry2_tag = s_q2;
  endtask

  // Expected query response from the model's in-flight list.
  task automatic exp_qry(input logic [2:0] t, output bit r, output logic [31:0] v);
    r = 0; v = 0;
    foreach (q[i]) begin
      if (q[i].tag == int'(t)) begin
        r = q[i].done;
        v = q[i].val;
`ifdef ROB_CDB_BYPASS_EN
        if (s_cv && s_ct == t) begin
          r = 1;
          v = s_cval;
        end
`endif
      end
    end
  endtask

  // One clock: check combinational outputs, drive stimulus, advance the model, queue expected outputs.
  task automatic step();
    bit          ci, fl, r;
    logic [31:0] v;
    out_t        o;
    ins_t        h, e;
    @(negedge clk_in);
    ci = (q.size() < 8) && !last_out.clr && !last_out.halt;
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, ci});
    chk("issue_tag", {29'd0, issue_tag}, next_tag);
    apply_inputs();
    #1;
    exp_qry(s_q1, r, v);
    chk("qry1_ready", {31'd0, qry1_ready}, {31'd0, r});
    if (r) chk("qry1_val", qry1_val, v);
    exp_qry(s_q2, r, v);
    chk("qry2_ready", {31'd0, qry2_ready}, {31'd0, r});
    if (r) chk("qry2_val", qry2_val, v);
    mon_en = 1;
    if (!s_rdy) begin
      exp_q.push_back(last_out);
    end else begin
      o = zero_out();
      o.halt = last_out.halt;
      fl = 0;
      if (q.size() > 0 && q[0].done && !last_out.halt) begin
        h = q.pop_front();
        case (h.ty)
          2'd0: begin o.idx = h.rd; o.val = h.val; o.rec = h.tag; end
          2'd2: begin o.sc = 1; o.st = h.tag; end
          2'd1: begin
            if (h.tk != h.pred) begin
              o.clr = 1; o.rv = 1;
              o.rpc = h.tk ? h.ja : h.pc + 32'd4;
              q.delete();
              next_tag = 0;
              fl = 1;
            end
          end
          default: o.halt = 1;
        endcase
      end
      if (!fl) begin
        if (s_cv && !last_out.clr) begin
          foreach (q[i]) begin
            if (q[i].tag == int'(s_ct)) begin
              q[i].val = s_cval; q[i].tk = s_ctk; q[i].done = 1;
            end
          end
        end
        if (s_iv && ci) begin
          e.ty = s_ty; e.rd = s_rd; e.pc = s_pc; e.pred = s_pred; e.ja = s_ja;
          e.val = 0; e.tk = 0; e.done = 0; e.tag = next_tag;
          q.push_back(e);
          next_tag = (next_tag + 1) % 8;
        end
      end
      last_out = o;
      exp_q.push_back(o);
    end
  endtask

  task automatic iss(input logic [1:0] ty, input logic [4:0] rd, input logic [31:0] pc,
                     input logic pred, input logic [31:0] ja);
    idle_set();
    s_iv = 1; s_ty = ty; s_rd = rd; s_pc = pc; s_pred = pred; s_ja = ja;
    step();
  endtask

  task automatic cdb(input int tag, input logic [31:0] val, input logic tk);
    idle_set();
    s_cv = 1; s_ct = 3'(tag); s_cval = val; s_ctk = tk;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      idle_set();
      step();
    end
  endtask

  task automatic do_reset();
    mon_en = 0;
    idle_set();
    apply_inputs();
    rst_n_in = 0;
    q.delete();
    exp_q.delete();
    next_tag = 0;
    last_out = zero_out();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1;
    #1;
    chk("rst_set_idx", {27'd0, rob_set_idx}, 0);
    chk("rst_store_commit", {31'd0, store_commit}, 0);
    chk("rst_rob_clear", {31'd0, rob_clear}, 0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 0);
    chk("rst_halt", {31'd0, halt}, 0);
    chk("rst_issue_ready", {31'd0, issue_ready}, 1);
    chk("rst_issue_tag", {29'd0, issue_tag}, 0);
  endtask

  // Issue CDB results for pending entries until the model's buffer is empty.
  task automatic drain();
    int pend[$];
    for (int g = 0; g < 300 && q.size() > 0; g++) begin
      idle_set();
      pend.delete();
      foreach (q[i]) if (!q[i].done) pend.push_back(i);
      if (pend.size() > 0) begin
        s_cv = 1;
        s_ct = 3'(q[pend[0]].tag);
        s_cval = $urandom;
        s_ctk = 1'($urandom_range(0, 1));
      end
      step();
    end
  endtask

  // Scoreboard monitor: every edge with the bench running consumes one expected output vector.
  initial begin
    out_t o;
    forever begin
      @(posedge clk_in);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow actual=empty expected=entry at t=%0t", $time);
        end else begin
          o = exp_q.pop_front();
          chk("rob_set_idx", {27'd0, rob_set_idx}, {27'd0, o.idx});
          if (o.idx != 0) begin
            chk("rob_set_reg_val", rob_set_reg_val, o.val);
            chk("rob_set_recorder", {29'd0, rob_set_recorder}, o.rec);
          end
          chk("store_commit", {31'd0, store_commit}, {31'd0, o.sc});
          if (o.sc) chk("store_commit_tag", {29'd0, store_commit_tag}, o.st);
          chk("rob_clear", {31'd0, rob_clear}, {31'd0, o.clr});
          chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, o.rv});
          if (o.rv) chk("redirect_pc", redirect_pc, o.rpc);
          chk("halt", {31'd0, halt}, {31'd0, o.halt});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int pend[$];
    int r;
    idle_set();
    apply_inputs();

    // Single REG instruction through to commit.
    do_reset();
    iss(2'd0, 5'd5, 32'h0, 1'b0, 32'h0);
    cdb(0, 32'h1234, 1'b0);
    idle(3);

    // Fill all eight entries, refused ninth issue, then wrap after the first retire.
    do_reset();
    for (int i = 0; i < 8; i++) iss(2'd0, 5'(i + 1), 32'(i * 4), 1'b0, 32'h0);
    iss(2'd0, 5'd20, 32'h40, 1'b0, 32'h0);
    cdb(0, 32'hA0, 1'b0);
    idle(2);
    iss(2'd2, 5'd0, 32'h44, 1'b0, 32'h0);
    drain();
    idle(2);

    // Out-of-order completion retires in program order.
    do_reset();
    for (int i = 0; i < 3; i++) iss(2'd0, 5'(10 + i), 32'(i * 4), 1'b0, 32'h0);
    cdb(2, 32'h22, 1'b0);
    cdb(1, 32'h11, 1'b0);
    cdb(0, 32'h00, 1'b0);
    idle(4);

    // Mispredict not-taken -> taken, younger entries squashed.
    do_reset();
    iss(2'd1, 5'd0, 32'h100, 1'b0, 32'h200);
    iss(2'd0, 5'd3, 32'h104, 1'b0, 32'h0);
    iss(2'd0, 5'd4, 32'h108, 1'b0, 32'h0);
    cdb(1, 32'h31, 1'b0);
    cdb(2, 32'h41, 1'b0);
    cdb(0, 32'h0, 1'b1);
    idle(4);
    // Mirror case: predicted taken, actually not taken.
    iss(2'd1, 5'd0, 32'h100, 1'b1, 32'h200);
    iss(2'd0, 5'd7, 32'h104, 1'b0, 32'h0);
    cdb(1, 32'h77, 1'b0);
    cdb(0, 32'h0, 1'b0);
    idle(4);

    // Stall while the head is ready, then stall while a commit pulse is visible.
    t0 = next_tag;
    iss(2'd0, 5'd6, 32'h300, 1'b0, 32'h0);
    cdb(t0, 32'h66, 1'b0);
    repeat (3) begin idle_set(); s_rdy = 0; step(); end
    idle(2);
    t0 = next_tag;
    iss(2'd0, 5'd8, 32'h304, 1'b0, 32'h0);
    cdb(t0, 32'h88, 1'b0);
    idle(1);
    repeat (2) begin idle_set(); s_rdy = 0; step(); end
    idle(2);

    // Query the entry being broadcast in the same cycle, then the cycle after.
    t0 = next_tag;
    iss(2'd0, 5'd9, 32'h400, 1'b0, 32'h0);
    idle_set(); s_cv = 1; s_ct = 3'(t0); s_cval = 32'hBEEF; s_q1 = 3'(t0); s_q2 = 3'(t0); step();
    idle_set(); s_q1 = 3'(t0); step();
    idle(2);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      idle_set();
      s_rdy = ($urandom_range(0, 9) != 0);
      s_iv = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      s_ty = (r < 7) ? 2'd0 : (r < 9) ? 2'd2 : 2'd1;
      s_rd = 5'($urandom_range(0, 31));
      s_pc = $urandom & 32'hFFFF_FFFC;
      s_pred = 1'($urandom_range(0, 1));
      s_ja = $urandom & 32'hFFFF_FFFC;
      s_q1 = 3'($urandom_range(0, 7));
      s_q2 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        pend.delete();
        foreach (q[i]) if (!q[i].done) pend.push_back(q[i].tag);
        s_cv = 1;
        s_ct = (pend.size() > 0 && $urandom_range(0, 7) != 0)
               ? 3'(pend[$urandom_range(0, pend.size() - 1)]) : 3'($urandom_range(0, 7));
        s_cval = $urandom;
        s_ctk = 1'($urandom_range(0, 1));
      end
      step();
    end
    drain();
    idle(2);

    // EXIT retires: halt sticks and further issues are refused.
    t0 = next_tag;
    iss(2'd3, 5'd0, 32'h500, 1'b0, 32'h0);
    cdb(t0, 32'h0, 1'b0);
    idle(2);
    iss(2'd0, 5'd1, 32'h504, 1'b0, 32'h0);
    idle(2);

    // Reset asserted while a commit pulse is on the outputs.
    do_reset();
    iss(2'd0, 5'd9, 32'h0, 1'b0, 32'h0);
    cdb(0, 32'hAB, 1'b0);
    idle_set();
    step();
    @(posedge clk_in);
    #3;
    chk("pre_reset_set_idx", {27'd0, rob_set_idx}, 9);
    mon_en = 0;
    rst_n_in = 0;
    #1;
    chk("async_rst_set_idx", {27'd0, rob_set_idx}, 0);
    chk("async_rst_reg_val", rob_set_reg_val, 0);
    chk("async_rst_issue_tag", {29'd0, issue_tag}, 0);
    @(negedge clk_in);
    rst_n_in = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer between the issue/decode stage and the register file. Allocates one entry per issued instruction and records results broadcast on the CDB. Retires instructions in program order, driving the register file's rob_set_* commit port. On a branch mispredict it raises rob_clear and redirects fetch.

Parameters:
ROB_SIZE_BIT, 3, log2 of entry count (8 entries); tag width; matches `ROB_SIZE_BIT.

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global stall; low = freeze all state
issue_valid  in  1  allocate entry this cycle
issue_type  in  2  0=REG write, 1=BRANCH, 2=STORE, 3=EXIT
issue_rd  in  5  destination register (0 = no write)
issue_pc  in  32  instruction PC
issue_pred_taken  in  1  fetch prediction (BRANCH only)
issue_jump_addr  in  32  branch target (BRANCH only)
issue_ready  out  1  entry free and no flush pending
issue_tag  out  ROB_SIZE_BIT  tag that the allocating instruction receives (= tail)
cdb_valid  in  1  result broadcast
cdb_tag  in  ROB_SIZE_BIT  producing entry
cdb_value  in  32  result value
cdb_taken  in  1  actual branch outcome
qry1_tag, qry2_tag  in  ROB_SIZE_BIT  operand lookup tags from issue
qry1_ready, qry2_ready  out  1  entry holds a result
qry1_val, qry2_val  out  32  entry value
rob_set_idx  out  5  committed rd (0 = no commit)
rob_set_reg_val  out  32  committed value
rob_set_recorder  out  ROB_SIZE_BIT  committed tag
store_commit  out  1  head STORE retired (1-cycle pulse)
store_commit_tag  out  ROB_SIZE_BIT  tag of retired store
rob_clear  out  1  flush pulse to RS/LSB/register file
redirect_valid  out  1  fetch redirect pulse
redirect_pc  out  32  corrected PC
halt  out  1  sticky; EXIT retired

Behaviour:
- State: per-entry valid, ready, type, rd, pc, pred, jump_addr, value, taken; head, tail, count (ROB_SIZE_BIT+1 bits).
- Reset (async, rst_n_in=0): all valid/ready=0; head=tail=count=0; every output register 0; halt=0.
- rdy_in=0: no state change; registered outputs hold.
- issue_ready = (count != 2^ROB_SIZE_BIT) && !rob_clear && !halt (combinational). Issue when issue_valid && issue_ready: write entry at tail, ready=0; tail+1 mod 2^N. issue_valid while !issue_ready is ignored.
- CDB: entry[cdb_tag] gets value/taken, ready=1, only if valid. Ignored for invalid entries and during the rob_clear cycle. STORE entries become ready via CDB (address/data resolved).
- Query: qry*_ready = valid && ready of entry[qry*_tag]; qry*_val = its value. No same-cycle CDB bypass (see Optional Feature).
- Commit: at most one per cycle, when head entry valid && ready. Outputs registered, visible the cycle after the commit edge, held for that cycle only; otherwise rob_set_idx=0, store_commit=0, rob_clear=0, redirect_valid=0.
  - REG: rob_set_idx=rd, rob_set_reg_val=value, rob_set_recorder=head tag.
  - STORE: store_commit=1, store_commit_tag=head.
  - BRANCH: if taken==pred, retire silently. Else rob_clear=1, redirect_valid=1, redirect_pc = taken ? jump_addr : pc+4 (mod 2^32). On that same edge, all entries are invalidated and head=tail=count=0. Any issue or CDB in that edge is discarded.
  - EXIT: halt=1 (sticky until reset); no further commits or issues.
- Simultaneous issue+commit: count unchanged; both take effect. Full + commit: issue_ready remains 0 that cycle (no same-cycle reuse).
- Wrap-around: head/tail wrap modulo 2^N; tag = index.
- Mispredict with younger entries in flight: those entries are discarded without commit.
- Reset asserted mid-commit: outputs drop to 0 immediately (async).

Optional Feature:
ROB_CDB_BYPASS_EN. Defined: if cdb_valid && cdb_tag==qry*_tag && entry valid, then qry*_ready=1 and qry*_val=cdb_value in the same cycle. Undefined: query reflects stored state only; result visible one cycle after broadcast.

Test Plan:
- Reset, then issue REG rd=5 (tag 0), CDB tag0 value 0x1234 -> next cycle commit; following cycle rob_set_idx=5, rob_set_reg_val=0x1234, rob_set_recorder=0.
- Issue 8 REG with no CDB -> issue_ready=0 after the 8th; 9th issue ignored. Commit tag0 -> issue_ready=1 the cycle after; next issue_tag=0 (wrap).
- Results out of order: CDB tag2, then tag1, then tag0 -> commits tag0, tag1, tag2 on consecutive cycles.
- BRANCH pc=0x100, pred=0, jump=0x200, CDB taken=1, two younger REG entries -> rob_clear=1, redirect_pc=0x200; younger entries never commit; count=0. Mirror case: pred=1, taken=0 -> redirect_pc=0x104.
- rdy_in=0 for 3 cycles while the head is ready -> no commit and outputs frozen; commit proceeds when rdy_in returns to 1.
- qry on a tag with CDB in the same cycle -> ready=0 without the macro, ready=1 with value with ROB_CDB_BYPASS_EN. EXIT commit -> halt=1 and issue_ready=0.
